// File: rtl/men_wb_pipe.sv
// Write-back pipeline register between the men stage and the register file.
// A main register and a skid register keep in_ready a pure flop output.
module men_wb_pipe #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 5,
  parameter int NCH           = 1,
  parameter int ZERO_SUPPRESS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NCH*DATA_W-1:0] men_wdata,
  input  logic [NCH*ADDR_W-1:0] men_addr,
  input  logic [NCH-1:0]        men_wd,
  input  logic                  flush,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [NCH*DATA_W-1:0] wdata,
  output logic [NCH*ADDR_W-1:0] addr,
  output logic [NCH-1:0]        wd,
  output logic [1:0]            occ
);

  // bit 0 = main valid, bit 1 = skid valid; skid is only ever full with main full
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_TWO   = 2'b11
  } state_t;

  state_t state, state_nxt;

  logic [NCH*DATA_W-1:0] main_wdata, skid_wdata;
  logic [NCH*ADDR_W-1:0] main_addr, skid_addr;
  logic [NCH-1:0]        main_wd, skid_wd;

  logic accept, consume;
  logic ld_main_in, ld_main_skid, ld_skid;

  assign in_ready  = ~state[1];
  assign out_valid = state[0];
  assign occ       = {state[1], state[0] & ~state[1]};
  assign wdata     = main_wdata;
  assign addr      = main_addr;

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  always_comb begin
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_nxt = S_EMPTY;
    end else begin
      unique case (state)
        S_EMPTY: begin
          if (accept) begin
            ld_main_in = 1'b1;
            state_nxt  = S_ONE;
          end
        end
        S_ONE: begin
          if (accept && consume) begin
            ld_main_in = 1'b1;
          end else if (accept) begin
            ld_skid   = 1'b1;
            state_nxt = S_TWO;
          end else if (consume) begin
            state_nxt = S_EMPTY;
          end
        end
        S_TWO: begin
          if (consume) begin
            ld_main_skid = 1'b1;
            state_nxt    = S_ONE;
          end
        end
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_wdata <= '0;
      main_addr  <= '0;
      main_wd    <= '0;
      skid_wdata <= '0;
      skid_addr  <= '0;
      skid_wd    <= '0;
    end else begin
      if (ld_main_in) begin
        main_wdata <= men_wdata;
        main_addr  <= men_addr;
        main_wd    <= men_wd;
      end else if (ld_main_skid) begin
        main_wdata <= skid_wdata;
        main_addr  <= skid_addr;
        main_wd    <= skid_wd;
      end
      if (ld_skid) begin
        skid_wdata <= men_wdata;
        skid_addr  <= men_addr;
        skid_wd    <= men_wd;
      end
    end
  end

  // each enable is qualified only by its own channel's address
  always_comb begin
    wd = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      wd[k] = main_wd[k] & out_valid &
              ((ZERO_SUPPRESS == 0) || (main_addr[k*ADDR_W +: ADDR_W] != '0));
    end
  end

endmodule

// File: tb/tb_men_wb_pipe.sv
// Bench for men_wb_pipe: scoreboard on the default instance plus
// directed checks on zero-suppress and two-channel variants.
module tb_men_wb_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // default instance: NCH=1, ZERO_SUPPRESS=1
  logic        in_valid0, in_ready0, flush0, out_ready0, out_valid0;
  logic [31:0] men_wdata0, wdata0;
  logic [4:0]  men_addr0, addr0;
  logic        men_wd0, wd0;
  logic [1:0]  occ0;

  men_wb_pipe #(.DATA_W(32), .ADDR_W(5), .NCH(1), .ZERO_SUPPRESS(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .men_wdata(men_wdata0), .men_addr(men_addr0), .men_wd(men_wd0),
    .flush(flush0), .out_ready(out_ready0), .out_valid(out_valid0),
    .wdata(wdata0), .addr(addr0), .wd(wd0), .occ(occ0)
  );

  // ZERO_SUPPRESS=0 instance
  logic        in_valid1, in_ready1, out_valid1, wd1;
  logic [31:0] wdata1;
  logic [4:0]  addr1;
  logic [1:0]  occ1;

  men_wb_pipe #(.DATA_W(32), .ADDR_W(5), .NCH(1), .ZERO_SUPPRESS(0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .men_wdata(32'h55), .men_addr(5'd0), .men_wd(1'b1),
    .flush(1'b0), .out_ready(1'b0), .out_valid(out_valid1),
    .wdata(wdata1), .addr(addr1), .wd(wd1), .occ(occ1)
  );

  // two-channel instance
  logic        in_valid2, in_ready2, out_valid2;
  logic [63:0] wdata2;
  logic [9:0]  addr2;
  logic [1:0]  wd2, occ2;

  men_wb_pipe #(.DATA_W(32), .ADDR_W(5), .NCH(2), .ZERO_SUPPRESS(1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .men_wdata(64'h0000_0066_0000_0065), .men_addr({5'd0, 5'd3}), .men_wd(2'b11),
    .flush(1'b0), .out_ready(1'b0), .out_valid(out_valid2),
    .wdata(wdata2), .addr(addr2), .wd(wd2), .occ(occ2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [37:0] sb_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [31:0] d, input logic [4:0] a, input logic w);
    in_valid0  = 1'b1;
    men_wdata0 = d;
    men_addr0  = a;
    men_wd0    = w;
  endtask

  // scoreboard: events decided at the coming edge are resolved here
  always @(negedge clk) begin
    logic [37:0] e;
    if (!rst) begin
      sb_q.delete();
    end else begin
      chk("occ", {62'd0, occ0}, sb_q.size());
      chk("in_ready", {63'd0, in_ready0}, sb_q.size() < 2);
      chk("out_valid", {63'd0, out_valid0}, sb_q.size() != 0);
      if (!out_valid0) chk("wd_idle", {63'd0, wd0}, 64'd0);
      if (flush0) begin
        sb_q.delete();
      end else begin
        if (out_valid0 && out_ready0) begin
          if (sb_q.size() == 0) begin
            chk("underflow", 64'd1, 64'd0);
          end else begin
            e = sb_q.pop_front();
            chk("bundle", {26'd0, wdata0, addr0, wd0}, {26'd0, e});
          end
        end
        if (in_valid0 && in_ready0)
          sb_q.push_back({men_wdata0, men_addr0, men_wd0 & (men_addr0 != 5'd0)});
      end
    end
  end

  initial begin
    rst = 1'b0;
    in_valid0 = 1'b0; men_wdata0 = '0; men_addr0 = '0; men_wd0 = 1'b0;
    flush0 = 1'b0; out_ready0 = 1'b0;
    in_valid1 = 1'b0; in_valid2 = 1'b0;

    #12;
    chk("rst_out_valid", {63'd0, out_valid0}, 64'd0);
    chk("rst_occ", {62'd0, occ0}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready0}, 64'd1);
    chk("rst_wd", {63'd0, wd0}, 64'd0);
    chk("rst_wdata", {32'd0, wdata0}, 64'd0);
    chk("rst_addr", {59'd0, addr0}, 64'd0);
    step();
    rst = 1'b1;

    // single transfer, latency 1
    push0(32'hDEADBEEF, 5'd5, 1'b1);
    out_ready0 = 1'b1;
    step();
    in_valid0 = 1'b0;
    chk("lat_out_valid", {63'd0, out_valid0}, 64'd1);
    chk("lat_wdata", {32'd0, wdata0}, 64'hDEADBEEF);
    chk("lat_addr", {59'd0, addr0}, 64'd5);
    chk("lat_wd", {63'd0, wd0}, 64'd1);
    chk("lat_occ", {62'd0, occ0}, 64'd1);
    step();

    // fill skid with consumer stalled, then drain in order
    out_ready0 = 1'b0;
    push0(32'h11, 5'd1, 1'b1);
    step();
    push0(32'h22, 5'd2, 1'b1);
    step();
    in_valid0 = 1'b0;
    chk("skid_occ", {62'd0, occ0}, 64'd2);
    chk("skid_in_ready", {63'd0, in_ready0}, 64'd0);
    chk("skid_wdata", {32'd0, wdata0}, 64'h11);
    out_ready0 = 1'b1;
    step();
    chk("drain1_wdata", {32'd0, wdata0}, 64'h22);
    chk("drain1_in_ready", {63'd0, in_ready0}, 64'd1);
    chk("drain1_occ", {62'd0, occ0}, 64'd1);
    step();
    chk("drain2_out_valid", {63'd0, out_valid0}, 64'd0);

    // register 0 suppression, with and without ZERO_SUPPRESS; two channels
    out_ready0 = 1'b0;
    push0(32'h33, 5'd0, 1'b1);
    in_valid1 = 1'b1;
    in_valid2 = 1'b1;
    step();
    in_valid0 = 1'b0; in_valid1 = 1'b0; in_valid2 = 1'b0;
    chk("zs1_out_valid", {63'd0, out_valid0}, 64'd1);
    chk("zs1_wd", {63'd0, wd0}, 64'd0);
    chk("zs0_out_valid", {63'd0, out_valid1}, 64'd1);
    chk("zs0_wd", {63'd0, wd1}, 64'd1);
    chk("nch2_out_valid", {63'd0, out_valid2}, 64'd1);
    chk("nch2_wd", {62'd0, wd2}, 64'd1);
    chk("nch2_wdata", wdata2, 64'h0000_0066_0000_0065);
    out_ready0 = 1'b1;
    step();

    // flush while full, with a competing accept
    out_ready0 = 1'b0;
    push0(32'h44, 5'd4, 1'b1);
    step();
    push0(32'h45, 5'd6, 1'b1);
    step();
    chk("pre_flush_occ", {62'd0, occ0}, 64'd2);
    flush0 = 1'b1;
    out_ready0 = 1'b1;
    push0(32'h46, 5'd7, 1'b1);
    step();
    flush0 = 1'b0;
    in_valid0 = 1'b0;
    chk("flush_occ", {62'd0, occ0}, 64'd0);
    chk("flush_out_valid", {63'd0, out_valid0}, 64'd0);
    chk("flush_wd", {63'd0, wd0}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready0}, 64'd1);
    chk("flush_keeps_data", {32'd0, wdata0}, 64'h44);

    // asynchronous reset between edges
    out_ready0 = 1'b0;
    push0(32'h77, 5'd7, 1'b1);
    step();
    in_valid0 = 1'b0;
    chk("pre_rst_occ", {62'd0, occ0}, 64'd1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, out_valid0}, 64'd0);
    chk("arst_occ", {62'd0, occ0}, 64'd0);
    chk("arst_wd", {63'd0, wd0}, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready0}, 64'd1);
    chk("arst_wdata", {32'd0, wdata0}, 64'd0);
    chk("arst_other_inst", {63'd0, out_valid1}, 64'd0);
    step();
    rst = 1'b1;
    push0(32'h99, 5'd9, 1'b1);
    step();
    in_valid0 = 1'b0;
    chk("post_rst_out_valid", {63'd0, out_valid0}, 64'd1);
    chk("post_rst_wdata", {32'd0, wdata0}, 64'h99);
    chk("post_rst_occ", {62'd0, occ0}, 64'd1);
    out_ready0 = 1'b1;
    step();

    // random traffic against the scoreboard
    repeat (400) begin
      in_valid0  = 1'($urandom_range(0, 1));
      men_wdata0 = $urandom;
      men_addr0  = 5'($urandom_range(0, 3));
      men_wd0    = 1'($urandom_range(0, 1));
      out_ready0 = 1'($urandom_range(0, 2) != 0);
      flush0     = ($urandom_range(0, 24) == 0);
      step();
    end
    in_valid0  = 1'b0;
    flush0     = 1'b0;
    out_ready0 = 1'b1;
    repeat (4) step();
    chk("drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
